// File: rtl/nonogram_sequencer.sv
// nonogram_sequencer: board-level phase controller for the nonogram pipeline.
// Sequences one board at a time through RECEIVE -> SOLVE -> TRANSMIT. A solve-phase
// watchdog diverts to ERROR. An abort input returns to RECEIVE from any phase.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_valid, rx_byte        UART byte strobe/data, mirrored on display
//   parsed, m_in, n_in       parser done pulse and board dimensions
//   solved, solution_in      solver done pulse and assigned-cell vector
//   assembled                assembler done pulse
//   abort                    synchronous abort request
//   state                    phase: 0 RECEIVE, 1 SOLVE, 2 TRANSMIT, 3 ERROR
//   sel_solver               FIFO source select (combinational decode of state)
//   solve_start, asm_start   one-cycle start pulses
//   m_out, n_out             latched dimensions
//   solution_out             latched solution
//   timeout_err              watchdog expiry flag
//   boards_done              completed-board counter (wraps)
//   display                  last received byte
//   solve_cycles             last solve duration
//
// Optional feature macro: SEQ_SOLVE_PROFILE_EN (solve-duration profiler).
// Without it, solve_cycles is tied to 0.
module nonogram_sequencer #(
    parameter int unsigned MAX_ROWS       = 11,
    parameter int unsigned MAX_COLS       = 11,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned CNT_W          = 8,
    localparam int unsigned ROW_W         = $clog2(MAX_ROWS + 1),
    localparam int unsigned COL_W         = $clog2(MAX_COLS + 1),
    localparam int unsigned SOL_W         = MAX_ROWS * MAX_COLS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_byte,
    input  logic             parsed,
    input  logic [ROW_W-1:0] m_in,
    input  logic [COL_W-1:0] n_in,
    input  logic             solved,
    input  logic [SOL_W-1:0] solution_in,
    input  logic             assembled,
    input  logic             abort,
    output logic [1:0]       state,
    output logic             sel_solver,
    output logic             solve_start,
    output logic             asm_start,
    output logic [ROW_W-1:0] m_out,
    output logic [COL_W-1:0] n_out,
    output logic [SOL_W-1:0] solution_out,
    output logic             timeout_err,
    output logic [CNT_W-1:0] boards_done,
    output logic [7:0]       display,
    output logic [31:0]      solve_cycles
);

    localparam int unsigned WD_W = 32;
    // Expiry fires when the watchdog holds TIMEOUT_CYCLES-1, so ERROR lands
    // exactly TIMEOUT_CYCLES cycles after SOLVE entry.
    localparam logic [WD_W-1:0] WD_LIMIT =
        (TIMEOUT_CYCLES == 0) ? '0 : WD_W'(TIMEOUT_CYCLES - 1);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_RECEIVE  = 2'd0,
        ST_SOLVE    = 2'd1,
        ST_TRANSMIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               solve_start_q, solve_start_d;
    logic               asm_start_q, asm_start_d;
    logic [ROW_W-1:0]   m_q, m_d;
    logic [COL_W-1:0]   n_q, n_d;
    logic [SOL_W-1:0]   sol_q, sol_d;
    logic               terr_q, terr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         disp_q, disp_d;
    logic [WD_W-1:0]    wd_q, wd_d;
`ifdef SEQ_SOLVE_PROFILE_EN
    logic [31:0]        prof_q, prof_d;
    logic [31:0]        scyc_q, scyc_d;
    logic [31:0]        prof_inc;

    // Saturating increment of the free-running solve counter.
    assign prof_inc = (prof_q == 32'hFFFF_FFFF) ? prof_q : prof_q + 32'd1;
`endif

    // State and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RECEIVE;
            solve_start_q <= 1'b0;
            asm_start_q   <= 1'b0;
            m_q           <= '0;
            n_q           <= '0;
            sol_q         <= '0;
            terr_q        <= 1'b0;
            cnt_q         <= '0;
            disp_q        <= '0;
            wd_q          <= '0;
`ifdef SEQ_SOLVE_PROFILE_EN
            prof_q        <= '0;
            scyc_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            solve_start_q <= solve_start_d;
            asm_start_q   <= asm_start_d;
            m_q           <= m_d;
            n_q           <= n_d;
            sol_q         <= sol_d;
            terr_q        <= terr_d;
            cnt_q         <= cnt_d;
            disp_q        <= disp_d;
            wd_q          <= wd_d;
`ifdef SEQ_SOLVE_PROFILE_EN
            prof_q        <= prof_d;
            scyc_q        <= scyc_d;
`endif
        end
    end

    // Next-state and next-output logic; abort outranks every phase event.
    always_comb begin
        state_d       = state_q;
        solve_start_d = 1'b0;
        asm_start_d   = 1'b0;
        m_d           = m_q;
        n_d           = n_q;
        sol_d         = sol_q;
        terr_d        = terr_q;
        cnt_d         = cnt_q;
        disp_d        = rx_valid ? rx_byte : disp_q;
        wd_d          = wd_q;
`ifdef SEQ_SOLVE_PROFILE_EN
        prof_d        = prof_q;
        scyc_d        = scyc_q;
`endif

        if (abort) begin
            state_d = ST_RECEIVE;
            terr_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_RECEIVE: begin
                    if (parsed) begin
                        m_d           = m_in;
                        n_d           = n_in;
                        state_d       = ST_SOLVE;
                        solve_start_d = 1'b1;
                        wd_d          = '0;
`ifdef SEQ_SOLVE_PROFILE_EN
                        prof_d        = '0;
`endif
                    end
                end
                ST_SOLVE: begin
                    if (WD_EN) begin
                        wd_d = wd_q + WD_W'(1);
                    end
`ifdef SEQ_SOLVE_PROFILE_EN
                    prof_d = prof_inc;
`endif
                    if (solved) begin
                        sol_d       = solution_in;
                        asm_start_d = 1'b1;
                        state_d     = ST_TRANSMIT;
`ifdef SEQ_SOLVE_PROFILE_EN
                        // Count includes the cycle that carries the solved pulse.
                        scyc_d      = prof_inc;
`endif
                    end else if (WD_EN && (wd_q == WD_LIMIT)) begin
                        state_d = ST_ERROR;
                        terr_d  = 1'b1;
                    end
                end
                ST_TRANSMIT: begin
                    if (assembled) begin
                        state_d = ST_RECEIVE;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
            endcase
        end
    end

    assign state        = state_q;
    assign sel_solver   = (state_q == ST_SOLVE);
    assign solve_start  = solve_start_q;
    assign asm_start    = asm_start_q;
    assign m_out        = m_q;
    assign n_out        = n_q;
    assign solution_out = sol_q;
    assign timeout_err  = terr_q;
    assign boards_done  = cnt_q;
    assign display      = disp_q;
`ifdef SEQ_SOLVE_PROFILE_EN
    assign solve_cycles = scyc_q;
`else
    assign solve_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_nonogram_sequencer.sv
// Self-checking bench for nonogram_sequencer: directed scenarios plus random
// stimulus, compared every cycle against a phase-level reference model.
module tb_nonogram_sequencer;

    localparam int unsigned TMO = 100;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_byte = '0;
    logic         parsed = 1'b0;
    logic [3:0]   m_in = '0;
    logic [3:0]   n_in = '0;
    logic         solved = 1'b0;
    logic [120:0] solution_in = '0;
    logic         assembled = 1'b0;
    logic         abort = 1'b0;

    logic [1:0]   dut_state;
    logic         dut_sel;
    logic         dut_ss;
    logic         dut_as;
    logic [3:0]   dut_m;
    logic [3:0]   dut_n;
    logic [120:0] dut_sol;
    logic         dut_terr;
    logic [7:0]   dut_cnt;
    logic [7:0]   dut_disp;
    logic [31:0]  dut_scyc;

    nonogram_sequencer #(
        .MAX_ROWS(11), .MAX_COLS(11), .TIMEOUT_CYCLES(TMO), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .parsed(parsed), .m_in(m_in), .n_in(n_in), .solved(solved),
        .solution_in(solution_in), .assembled(assembled), .abort(abort),
        .state(dut_state), .sel_solver(dut_sel), .solve_start(dut_ss),
        .asm_start(dut_as), .m_out(dut_m), .n_out(dut_n),
        .solution_out(dut_sol), .timeout_err(dut_terr),
        .boards_done(dut_cnt), .display(dut_disp), .solve_cycles(dut_scyc)
    );

    always #5 clk = ~clk;

    // Reference model: phase as an integer, time in SOLVE as a plain count.
    int           e_phase;
    longint       age;
    bit           e_ss, e_as, e_terr;
    logic [3:0]   e_m, e_n;
    logic [120:0] e_sol;
    int           e_cnt;
    logic [7:0]   e_disp;
    logic [31:0]  e_scyc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_phase = 0; age = 0; e_ss = 0; e_as = 0; e_terr = 0;
            e_m = '0; e_n = '0; e_sol = '0; e_cnt = 0; e_disp = '0; e_scyc = '0;
        end else begin
            e_ss = 0;
            e_as = 0;
            if (rx_valid) e_disp = rx_byte;
            if (abort) begin
                e_phase = 0;
                e_terr  = 0;
            end else if (e_phase == 0) begin
                if (parsed) begin
                    e_m = m_in; e_n = n_in; e_phase = 1; e_ss = 1; age = 0;
                end
            end else if (e_phase == 1) begin
                age = age + 1;
                if (solved) begin
                    e_sol = solution_in; e_as = 1; e_phase = 2;
`ifdef SEQ_SOLVE_PROFILE_EN
                    e_scyc = (age > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(age);
`endif
                end else if (TMO != 0 && age == longint'(TMO)) begin
                    e_phase = 3; e_terr = 1;
                end
            end else if (e_phase == 2) begin
                if (assembled) begin
                    e_cnt = (e_cnt + 1) % 256; e_phase = 0;
                end
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("state",        128'(dut_state), 128'(e_phase[1:0]));
        chk("sel_solver",   128'(dut_sel),   128'(e_phase == 1));
        chk("solve_start",  128'(dut_ss),    128'(e_ss));
        chk("asm_start",    128'(dut_as),    128'(e_as));
        chk("m_out",        128'(dut_m),     128'(e_m));
        chk("n_out",        128'(dut_n),     128'(e_n));
        chk("solution_out", 128'(dut_sol),   128'(e_sol));
        chk("timeout_err",  128'(dut_terr),  128'(e_terr));
        chk("boards_done",  128'(dut_cnt),   128'(e_cnt[7:0]));
        chk("display",      128'(dut_disp),  128'(e_disp));
        chk("solve_cycles", 128'(dut_scyc),  128'(e_scyc));
    endtask

    // One clock: inputs already set, sample 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    function automatic logic [120:0] rnd_sol();
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        return w[120:0];
    endfunction

    logic [31:0] exp_prof;

    initial begin
`ifdef SEQ_SOLVE_PROFILE_EN
        exp_prof = 32'd20;
`else
        exp_prof = 32'd0;
`endif
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state",  128'(dut_state), 128'd0);
        chk("reset count",  128'(dut_cnt),   128'd0);
        chk("reset sol",    128'(dut_sol),   128'd0);
        compare_all();
        rst = 1'b0;
        idle(2);

        // Board 1: 11x11, solved 20 cycles after solve_start.
        m_in = 4'd11; n_in = 4'd11; parsed = 1'b1;
        cyc();
        parsed = 1'b0;
        chk("enter solve",   128'(dut_state), 128'd1);
        chk("ss pulse",      128'(dut_ss),    128'd1);
        chk("m latched",     128'(dut_m),     128'd11);
        chk("n latched",     128'(dut_n),     128'd11);
        chk("sel in solve",  128'(dut_sel),   128'd1);
        cyc();
        chk("ss one cycle",  128'(dut_ss),    128'd0);
        idle(18);
        solution_in = 121'h1; solved = 1'b1;
        cyc();
        solved = 1'b0;
        chk("enter tx",      128'(dut_state), 128'd2);
        chk("as pulse",      128'(dut_as),    128'd1);
        chk("sol latched",   128'(dut_sol),   128'h1);
        chk("solve cycles",  128'(dut_scyc),  128'(exp_prof));
        cyc();
        chk("as one cycle",  128'(dut_as),    128'd0);
        assembled = 1'b1;
        cyc();
        assembled = 1'b0;
        chk("back to rx",    128'(dut_state), 128'd0);
        chk("one board",     128'(dut_cnt),   128'd1);

        // Watchdog expiry exactly TMO cycles after SOLVE entry.
        parsed = 1'b1;
        cyc();
        parsed = 1'b0;
        idle(int'(TMO) - 1);
        chk("pre-expiry",    128'(dut_state), 128'd1);
        cyc();
        chk("error state",   128'(dut_state), 128'd3);
        chk("timeout flag",  128'(dut_terr),  128'd1);
        solved = 1'b1;
        idle(3);
        solved = 1'b0;
        chk("error holds",   128'(dut_state), 128'd3);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort rx",      128'(dut_state), 128'd0);
        chk("abort clr err", 128'(dut_terr),  128'd0);
        chk("abort count",   128'(dut_cnt),   128'd1);

        // solved coinciding with expiry wins.
        parsed = 1'b1;
        cyc();
        parsed = 1'b0;
        idle(int'(TMO) - 1);
        solution_in = 121'h1; solved = 1'b1;
        cyc();
        solved = 1'b0;
        chk("solved beats wd", 128'(dut_state), 128'd2);
        chk("no timeout",      128'(dut_terr),  128'd0);
        assembled = 1'b1;
        cyc();
        assembled = 1'b0;

        // abort coinciding with solved wins.
        parsed = 1'b1;
        cyc();
        parsed = 1'b0;
        idle(3);
        solution_in = rnd_sol() | 121'h2; solved = 1'b1; abort = 1'b1;
        cyc();
        solved = 1'b0; abort = 1'b0;
        chk("abort beats solved", 128'(dut_state), 128'd0);
        chk("abort no as",        128'(dut_as),    128'd0);
        chk("abort keeps sol",    128'(dut_sol),   128'h1);

        // Counter wrap: two boards done so far, 254 more reach 256.
        m_in = 4'd11;
        for (int i = 0; i < 254; i++) begin
            parsed = 1'b1; cyc(); parsed = 1'b0;
            solution_in = rnd_sol(); solved = 1'b1; cyc(); solved = 1'b0;
            if (i == 10) begin
                m_in = 4'd3; parsed = 1'b1; cyc(); parsed = 1'b0; m_in = 4'd11;
                chk("parsed ignored tx", 128'(dut_m), 128'd11);
            end
            assembled = 1'b1; cyc(); assembled = 1'b0;
        end
        chk("count wrap", 128'(dut_cnt), 128'd0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            parsed      = ($urandom_range(0, 3) == 0);
            m_in        = 4'($urandom);
            n_in        = 4'($urandom);
            solved      = ($urandom_range(0, 63) == 0);
            solution_in = rnd_sol();
            assembled   = ($urandom_range(0, 3) == 0);
            abort       = ($urandom_range(0, 63) == 0);
            rx_valid    = $urandom_range(0, 1) == 1;
            rx_byte     = 8'($urandom);
            cyc();
        end
        parsed = 1'b0; solved = 1'b0; assembled = 1'b0; rx_valid = 1'b0;
        abort = 1'b1;
        cyc();
        abort = 1'b0;

        // Asynchronous reset mid-SOLVE.
        m_in = 4'd7; parsed = 1'b1;
        cyc();
        parsed = 1'b0;
        idle(3);
        #2 rst = 1'b1;
        #1;
        chk("async state", 128'(dut_state), 128'd0);
        chk("async sel",   128'(dut_sel),   128'd0);
        chk("async m",     128'(dut_m),     128'd0);
        chk("async count", 128'(dut_cnt),   128'd0);
        chk("async sol",   128'(dut_sol),   128'd0);
        compare_all();
        #1 rst = 1'b0;
        rx_valid = 1'b1; rx_byte = 8'hA5;
        cyc();
        rx_valid = 1'b0;
        chk("display A5", 128'(dut_disp), 128'hA5);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/nonogram_sequencer.md
Name: nonogram_sequencer

Overview:
Parametrised board-level phase controller for the nonogram pipeline. It sequences one board at a time through receive/parse, solve and assemble/transmit. It owns the FIFO write-source select and latches board dimensions and the solution between phases. Over the current hard-wired 11x11 phase logic it adds:
- a solve-phase watchdog with an error state,
- an abort input,
- one-cycle start pulses to the downstream stages,
- a completed-board counter.

Parameters:
MAX_ROWS, 11, maximum board rows; ROW_W = $clog2(MAX_ROWS+1)
MAX_COLS, 11, maximum board columns; COL_W = $clog2(MAX_COLS+1)
TIMEOUT_CYCLES, 50_000_000, solve-phase cycle limit; 0 disables the watchdog
CNT_W, 8, width of completed-board counter

Ports:
clk  in  1  system clock (50 MHz domain)
rst  in  1  asynchronous, active-high reset
rx_valid  in  1  UART receiver byte strobe
rx_byte  in  8  UART received byte
parsed  in  1  parser board-done pulse
m_in  in  ROW_W  parsed row count
n_in  in  COL_W  parsed column count
solved  in  1  solver done pulse
solution_in  in  MAX_ROWS*MAX_COLS  solver assigned-cell vector
assembled  in  1  assembler done pulse
abort  in  1  synchronous abort request, sampled each cycle
state  out  2  phase: 0 RECEIVE, 1 SOLVE, 2 TRANSMIT, 3 ERROR
sel_solver  out  1  FIFO write/data select: 0 parser, 1 solver
solve_start  out  1  one-cycle pulse to the solver
asm_start  out  1  one-cycle pulse to the assembler
m_out  out  ROW_W  latched rows
n_out  out  COL_W  latched columns
solution_out  out  MAX_ROWS*MAX_COLS  latched solution
timeout_err  out  1  watchdog expiry flag
boards_done  out  CNT_W  completed-board count
display  out  8  last received byte
solve_cycles  out  32  last solve duration (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state=RECEIVE. All outputs and registers are 0, including the watchdog and counter.
- All outputs are registered, except sel_solver = (state==SOLVE), decoded from the state register.
- display: loads rx_byte on every cycle with rx_valid=1, in any state.
- RECEIVE:
  - parsed=1 at edge k: m_out/n_out latch m_in/n_in at k.
  - state=SOLVE and solve_start=1 at k+1; solve_start is low again at k+2.
  - Watchdog clears to 0 at k+1.
- SOLVE:
  - Watchdog increments each cycle.
  - solved=1: solution_out latches solution_in, asm_start pulses next cycle, state=TRANSMIT.
  - If TIMEOUT_CYCLES != 0 and the watchdog reaches TIMEOUT_CYCLES-1 with no solved: state=ERROR and timeout_err=1 next cycle.
- TRANSMIT: assembled=1 -> state=RECEIVE and boards_done+1 next cycle. The counter wraps modulo 2^CNT_W.
- ERROR: holds state and timeout_err until abort=1, then RECEIVE next cycle with timeout_err=0.
- abort=1 in any state -> RECEIVE next cycle:
  - no start pulses, no counter change;
  - m_out/n_out/solution_out keep their values.
- Priorities within a cycle: abort > solved > watchdog expiry.
- parsed/solved/assembled arriving in a non-matching state are ignored, with no side effects.
- Each phase transition takes exactly 1 cycle after its trigger; back-to-back boards need no idle cycle.
- Reset asserted mid-phase: immediate return to RECEIVE and all registers cleared. Pulses in flight are dropped.

Optional Feature:
- Macro: SEQ_SOLVE_PROFILE_EN.
- Defined: a 32-bit free counter runs during SOLVE. On the solved transition, solve_cycles loads that count, i.e. the number of cycles spent in SOLVE. The counter saturates at 2^32-1. Timeout and abort leave solve_cycles unchanged.
- Undefined: no counter is synthesised and solve_cycles is tied to 0.

Test Plan:
- Reset, then pulse parsed with m_in=11, n_in=11 -> next cycle: state=1, solve_start high for exactly 1 cycle, m_out=11, n_out=11, sel_solver=1.
- Pulse solved 20 cycles after solve_start with solution_in=121'h1 -> next cycle: state=2, asm_start 1-cycle pulse, solution_out=121'h1. Then assembled -> state=0, boards_done=1. With SEQ_SOLVE_PROFILE_EN: solve_cycles=20.
- TIMEOUT_CYCLES=100, no solved -> ERROR entered exactly 100 cycles after SOLVE entry, timeout_err=1. Then abort -> state=0, timeout_err=0, boards_done unchanged.
- solved and watchdog expiry in the same cycle -> TRANSMIT, timeout_err stays 0. abort and solved in the same cycle -> RECEIVE, no asm_start.
- 256 complete boards with CNT_W=8 -> boards_done wraps to 0. parsed pulsed during TRANSMIT -> ignored, m_out unchanged.
- Assert rst asynchronously mid-SOLVE (between clock edges) -> state=0 and all outputs 0 before the next edge. rx_valid with rx_byte=8'hA5 -> display=8'hA5.
